// File: rtl/mix_columns_if.sv
// Handshake bundle for mix_columns_engine: input state channel, output state channel, busy flag.
interface mix_columns_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic         in_bypass;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_mode, in_bypass, in_state, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_mode, in_bypass, in_state, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: transforms COLS_PER_CYCLE columns per clock,
// GF(2^8) products built from xtime chains, with per-transaction mode and final-round bypass.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic          clk,
  input logic          rst_n,
  mix_columns_if.slave bus
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // STEP wraps to 0 when all four columns are done in one cycle.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_fsm;
  state_t         w_fsm_nxt;
  logic [127:0]   r_data;
  logic [127:0]   w_data_nxt;
  logic [1:0]     r_col;
  logic [1:0]     w_idx;
  logic           r_mode;
  logic           w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  b  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [31:0] res;
    logic [1:0]  k1;
    logic [1:0]  k2;
    logic [1:0]  k3;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      b[i]  = col[31-8*i -: 8];
      x2[i] = xtime(b[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      k1 = 2'(i + 1);
      k2 = 2'(i + 2);
      k3 = 2'(i + 3);
      // Inverse coefficients: 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1.
      if (inv) begin
        res[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[k1] ^ x2[k1] ^ b[k1])
                         ^ (x8[k2] ^ x4[k2] ^ b[k2]) ^ (x8[k3] ^ b[k3]);
      end else begin
        res[31-8*i -: 8] = x2[i] ^ (x2[k1] ^ b[k1]) ^ b[k2] ^ b[k3];
      end
    end
    return res;
  endfunction

  assign w_accept      = bus.in_valid && (r_fsm == S_IDLE);
  assign bus.in_ready  = rst_n && (r_fsm == S_IDLE);
  assign bus.out_valid = (r_fsm == S_DONE);
  assign bus.busy      = (r_fsm != S_IDLE);
  assign bus.out_state = r_data;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_fsm_nxt = bus.in_bypass ? S_DONE : S_RUN;
        end else begin
          w_fsm_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_col == LAST) begin
          w_fsm_nxt = S_DONE;
        end else begin
          w_fsm_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_fsm_nxt = S_IDLE;
        end else begin
          w_fsm_nxt = S_DONE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Replace the current column group with its transform.
  always_comb begin
    w_data_nxt = r_data;
    w_idx      = 2'd0;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      w_idx = r_col + 2'(g);
      w_data_nxt[127-32*int'(w_idx) -: 32] = mix_col(r_data[127-32*int'(w_idx) -: 32], r_mode);
    end
  end

  // State, column counter and mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 128'd0;
      r_col  <= 2'd0;
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_data <= bus.in_state;
      r_col  <= 2'd0;
      r_mode <= bus.in_mode;
    end else if (r_fsm == S_RUN) begin
      r_data <= w_data_nxt;
      r_col  <= r_col + STEP;
    end else begin
      r_data <= r_data;
      r_col  <= r_col;
      r_mode <= r_mode;
    end
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed and random self-checking bench for mix_columns_engine at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mix_columns_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [3];
  logic         in_mode   [3];
  logic         in_bypass [3];
  logic         out_ready [3];
  logic [127:0] in_state  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         busy      [3];
  logic [127:0] out_state [3];
  int           checks = 0;
  int           errors = 0;

  localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] V_BP_IN = 128'hc6c6c6c6_d4d4d4d5_01010101_2d26314c;
  localparam logic [127:0] V_BP_EX = 128'hc6c6c6c6_d5d5d7d6_01010101_4d7ebdf8;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_if u_if ();
    mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
    );
    assign u_if.in_valid  = in_valid[g];
    assign u_if.in_mode   = in_mode[g];
    assign u_if.in_bypass = in_bypass[g];
    assign u_if.in_state  = in_state[g];
    assign u_if.out_ready = out_ready[g];
    assign in_ready[g]    = u_if.in_ready;
    assign out_valid[g]   = u_if.out_valid;
    assign out_state[g]   = u_if.out_state;
    assign busy[g]        = u_if.busy;
  end

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'd0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] st, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[(j - r + 4) % 4], st[127-32*c-8*j -: 8]);
        res[127-32*c-8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic send(input int d, input logic [127:0] st, input logic mode, input logic byp,
                      output bit ok);
    int n;
    in_state[d] = st; in_mode[d] = mode; in_bypass[d] = byp; in_valid[d] = 1'b1;
    n = 0;
    while (in_ready[d] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    ok = (in_ready[d] === 1'b1);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
    if (out_valid[d] !== 1'b1) lat = -1;
  endtask

  task automatic take(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({in_ready[d], out_valid[d], busy[d]} !== 3'b000 || out_state[d] !== 128'd0) begin
        errors++;
        $display("FAIL reset_outputs d=%0d rdy/vld/busy=%b%b%b state=%h required 000 and 0",
                 d, in_ready[d], out_valid[d], busy[d], out_state[d]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_ready d=%0d got %b required 1", d, in_ready[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward_c1();
    bit ok; int lat;
    send(0, V_PLAIN, 1'b0, 1'b0, ok);
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL fwd_busy got %b required 1", busy[0]); end
    wait_valid(0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL fwd_c1_latency got %0d required 4", lat); end
    checks++;
    if (out_state[0] !== V_MIXED) begin
      errors++; $display("FAIL fwd_c1_state got %h required %h", out_state[0], V_MIXED);
    end
    take(0);
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL fwd_c1_after_take vld=%b rdy=%b required 0 1", out_valid[0], in_ready[0]);
    end
  endtask

  task automatic test_inverse_c4();
    bit ok; int lat;
    send(2, V_MIXED, 1'b1, 1'b0, ok);
    wait_valid(2, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL inv_c4_latency got %0d required 1", lat); end
    checks++;
    if (out_state[2] !== V_PLAIN) begin
      errors++; $display("FAIL inv_c4_state got %h required %h", out_state[2], V_PLAIN);
    end
    take(2);
    send(1, V_MIXED, 1'b1, 1'b0, ok);
    wait_valid(1, lat);
    checks++;
    if (lat !== 2 || out_state[1] !== V_PLAIN) begin
      errors++;
      $display("FAIL inv_c2 lat=%0d state=%h required 2 and %h", lat, out_state[1], V_PLAIN);
    end
    take(1);
  endtask

  task automatic test_bypass();
    bit ok; int lat;
    for (int d = 0; d < 2; d++) begin
      send(d, V_BYP, 1'(d == 0), 1'b1, ok);
      wait_valid(d, lat);
      checks++;
      if (lat !== 0) begin
        errors++; $display("FAIL byp_latency d=%0d valid after %0d more edges required 0", d, lat);
      end
      checks++;
      if (out_state[d] !== V_BYP) begin
        errors++; $display("FAIL byp_state d=%0d got %h required %h", d, out_state[d], V_BYP);
      end
      take(d);
      in_bypass[d] = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    send(1, V_BP_IN, 1'b0, 1'b0, ok);
    wait_valid(1, lat);
    for (int k = 0; k < 10; k++) begin
      in_valid[1] = (k < 6); in_mode[1] = 1'(k); in_bypass[1] = 1'(k);
      in_state[1] = {4{$urandom}};
      checks++;
      if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 || out_state[1] !== V_BP_EX) begin
        errors++;
        $display("FAIL bp_hold k=%0d vld=%b rdy=%b state=%h required 1 0 %h",
                 k, out_valid[1], in_ready[1], out_state[1], V_BP_EX);
      end
      @(posedge clk); #1;
    end
    in_valid[1] = 1'b0; in_bypass[1] = 1'b0;
    take(1);
    checks++;
    if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rdy=%b vld=%b required 1 0", in_ready[1], out_valid[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok; int lat;
    send(0, V_PLAIN, 1'b0, 1'b0, ok);
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got %b required 1", busy[0]); end
    #2; rst_n = 1'b0; #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_state[0] !== 128'd0 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async vld=%b rdy=%b state=%h required 0 0 0",
               out_valid[0], in_ready[0], out_state[0]);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; #1;
    checks++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release rdy=%b busy=%b required 1 0", in_ready[0], busy[0]);
    end
    send(0, V_BP_IN, 1'b0, 1'b0, ok);
    wait_valid(0, lat);
    checks++;
    if (lat !== 4 || out_state[0] !== V_BP_EX) begin
      errors++;
      $display("FAIL rst_mid_next lat=%0d state=%h required 4 %h", lat, out_state[0], V_BP_EX);
    end
    take(0);
  endtask

  task automatic test_back_to_back();
    int seen [$];
    logic [127:0] exp;
    exp = model(V_BYP, 1'b0);
    in_state[1] = V_BYP; in_mode[1] = 1'b0; in_bypass[1] = 1'b0;
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid[1] === 1'b1) begin
        seen.push_back(k);
        checks++;
        if (out_state[1] !== exp) begin
          errors++; $display("FAIL b2b_state k=%0d got %h required %h", k, out_state[1], exp);
        end
      end
    end
    in_valid[1] = 1'b0;
    for (int k = 0; k < 10 && busy[1] !== 1'b0; k++) begin @(posedge clk); #1; end
    out_ready[1] = 1'b0;
    checks++;
    if (seen.size() < 9) begin
      errors++; $display("FAIL b2b_count got %0d results required at least 9", seen.size());
    end
    for (int i = 1; i < seen.size(); i++) begin
      checks++;
      if (seen[i] - seen[i-1] !== 4) begin
        errors++; $display("FAIL b2b_period got %0d cycles required 4", seen[i] - seen[i-1]);
      end
    end
  endtask

  task automatic test_roundtrip();
    bit ok; int lat;
    logic [127:0] st, fwd;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 1000; n++) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        send(d, st, 1'b0, 1'b0, ok);
        wait_valid(d, lat);
        fwd = out_state[d];
        take(d);
        checks++;
        if (lat < 0 || fwd !== model(st, 1'b0)) begin
          errors++;
          $display("FAIL rt_forward d=%0d in=%h got %h required %h", d, st, fwd, model(st, 1'b0));
        end
        send(d, fwd, 1'b1, 1'b0, ok);
        wait_valid(d, lat);
        checks++;
        if (lat < 0 || out_state[d] !== st) begin
          errors++; $display("FAIL rt_inverse d=%0d got %h required %h", d, out_state[d], st);
        end
        take(d);
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_mode[d] = 1'b0; in_bypass[d] = 1'b0;
      out_ready[d] = 1'b0; in_state[d] = 128'd0;
    end
    test_reset();
    test_forward_c1();
    test_inverse_c4();
    test_bypass();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_roundtrip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
